// File: rtl/bypass_pkg.sv
// Shared constants for the bypass/hazard unit: IR field positions, opcodes,
// forwarding-mux encodings and the mult/div scoreboard state type.
package bypass_pkg;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 17;
  localparam int RT_HI    = 16;
  localparam int RT_LO    = 12;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_XM = 2'b01;
  localparam logic [1:0] SEL_MW = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_TOUT = 2'b10
  } md_state_e;

endpackage

// File: rtl/ir_decode.sv
// Per-stage instruction decode: source/destination registers with valid bits.
// Register 0 is never reported as a valid source or destination.
module ir_decode
  import bypass_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic [XLEN-1:0]  ir,
  output logic [REG_W-1:0] src_a,
  output logic             src_a_v,
  output logic [REG_W-1:0] src_b,
  output logic             src_b_v,
  output logic [REG_W-1:0] dst,
  output logic             dst_v,
  output logic             is_lw,
  output logic             is_sw,
  output logic             is_md
);

  logic [4:0]       opcode;
  logic [4:0]       aluop;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             unused_ir_bits;

  assign opcode = ir[OP_HI:OP_LO];
  assign aluop  = ir[ALUOP_HI:ALUOP_LO];
  assign rd     = REG_W'(ir[RD_HI:RD_LO]);
  assign rs     = REG_W'(ir[RS_HI:RS_LO]);
  assign rt     = REG_W'(ir[RT_HI:RT_LO]);
  assign unused_ir_bits = ^{ir[11:7], ir[1:0]};

  always_comb begin
    src_a   = '0;
    src_a_v = 1'b0;
    src_b   = '0;
    src_b_v = 1'b0;
    dst     = '0;
    dst_v   = 1'b0;
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_md   = (opcode == OP_R) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
    case (opcode)
      OP_R: begin
        src_a = rs; src_a_v = 1'b1;
        src_b = rt; src_b_v = 1'b1;
        // mul/div results come back through the scoreboard, not the pipe
        if (!is_md) begin
          dst = rd; dst_v = 1'b1;
        end
      end
      OP_ADDI, OP_LW: begin
        src_a = rs; src_a_v = 1'b1;
        dst   = rd; dst_v   = 1'b1;
      end
      OP_SW: begin
        src_a = rs; src_a_v = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        src_a = rd; src_a_v = 1'b1;
        src_b = rs; src_b_v = 1'b1;
      end
      OP_JR: begin
        src_a = rd; src_a_v = 1'b1;
      end
      OP_JAL: begin
        dst = REG_W'(31); dst_v = 1'b1;
      end
      OP_SETX: begin
        dst = REG_W'(30); dst_v = 1'b1;
      end
      OP_BEX: begin
        src_a = REG_W'(30); src_a_v = 1'b1;
      end
      default: ;
    endcase
    if (src_a == '0) src_a_v = 1'b0;
    if (src_b == '0) src_b_v = 1'b0;
    if (dst == '0)   dst_v   = 1'b0;
  end

endmodule

// File: rtl/bypass_hazard_unit.sv
// Forwarding mux control, load-use stall and mult/div scoreboard for the
// 5-stage pipeline. Define BYPASS_PERF_EN to build the stall perf counter.
module bypass_hazard_unit
  import bypass_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_W      = 5,
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [XLEN-1:0]  fd_ir,
  input  logic [XLEN-1:0]  dx_ir,
  input  logic [XLEN-1:0]  xm_ir,
  input  logic [XLEN-1:0]  mw_ir,
  input  logic             md_start,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic [1:0]       mux_a_sel,
  output logic [1:0]       mux_b_sel,
  output logic             mux_st_sel,
  output logic             stall,
  output logic             md_busy,
  output logic [REG_W-1:0] md_rd,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TCW = $clog2(MD_TIMEOUT + 1);
  localparam logic [REG_W-1:0] R30 = REG_W'(30);

  logic [REG_W-1:0] fd_src_a, fd_src_b, fd_dst, dx_src_a, dx_src_b, dx_dst;
  logic [REG_W-1:0] xm_src_a, xm_src_b, xm_dst, mw_src_a, mw_src_b, mw_dst;
  logic fd_src_a_v, fd_src_b_v, fd_dst_v, fd_is_lw, fd_is_sw, fd_is_md;
  logic dx_src_a_v, dx_src_b_v, dx_dst_v, dx_is_lw, dx_is_sw, dx_is_md;
  logic xm_src_a_v, xm_src_b_v, xm_dst_v, xm_is_lw, xm_is_sw, xm_is_md;
  logic mw_src_a_v, mw_src_b_v, mw_dst_v, mw_is_lw, mw_is_sw, mw_is_md;

  ir_decode #(.XLEN(XLEN), .REG_W(REG_W)) u_dec_fd (
    .ir(fd_ir), .src_a(fd_src_a), .src_a_v(fd_src_a_v), .src_b(fd_src_b), .src_b_v(fd_src_b_v),
    .dst(fd_dst), .dst_v(fd_dst_v), .is_lw(fd_is_lw), .is_sw(fd_is_sw), .is_md(fd_is_md));
  ir_decode #(.XLEN(XLEN), .REG_W(REG_W)) u_dec_dx (
    .ir(dx_ir), .src_a(dx_src_a), .src_a_v(dx_src_a_v), .src_b(dx_src_b), .src_b_v(dx_src_b_v),
    .dst(dx_dst), .dst_v(dx_dst_v), .is_lw(dx_is_lw), .is_sw(dx_is_sw), .is_md(dx_is_md));
  ir_decode #(.XLEN(XLEN), .REG_W(REG_W)) u_dec_xm (
    .ir(xm_ir), .src_a(xm_src_a), .src_a_v(xm_src_a_v), .src_b(xm_src_b), .src_b_v(xm_src_b_v),
    .dst(xm_dst), .dst_v(xm_dst_v), .is_lw(xm_is_lw), .is_sw(xm_is_sw), .is_md(xm_is_md));
  ir_decode #(.XLEN(XLEN), .REG_W(REG_W)) u_dec_mw (
    .ir(mw_ir), .src_a(mw_src_a), .src_a_v(mw_src_a_v), .src_b(mw_src_b), .src_b_v(mw_src_b_v),
    .dst(mw_dst), .dst_v(mw_dst_v), .is_lw(mw_is_lw), .is_sw(mw_is_sw), .is_md(mw_is_md));

  logic unused_dec;
  assign unused_dec = ^{fd_is_lw, dx_is_sw, dx_is_md, xm_src_a, xm_src_a_v, xm_src_b,
                        xm_src_b_v, xm_is_md, mw_src_a, mw_src_a_v, mw_src_b, mw_src_b_v,
                        mw_is_lw, mw_is_sw, mw_is_md, md_exception};

  // Store data sits in the rd field of sw; it is a source for stall purposes.
  logic [REG_W-1:0] fd_rd, dx_rd, xm_rd;
  assign fd_rd = REG_W'(fd_ir[RD_HI:RD_LO]);
  assign dx_rd = REG_W'(dx_ir[RD_HI:RD_LO]);
  assign xm_rd = REG_W'(xm_ir[RD_HI:RD_LO]);

  // A loaded value is not available at X/M, so a lw there falls through to M/W.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src, input logic src_v);
    if (src_v && xm_dst_v && !xm_is_lw && (xm_dst == src)) return SEL_XM;
    else if (src_v && mw_dst_v && (mw_dst == src))        return SEL_MW;
    else                                                   return SEL_RF;
  endfunction

  assign mux_a_sel  = fwd_sel(dx_src_a, dx_src_a_v);
  assign mux_b_sel  = fwd_sel(dx_src_b, dx_src_b_v);
  assign mux_st_sel = xm_is_sw && (xm_rd != '0) && mw_dst_v && (mw_dst == xm_rd);

  function automatic logic fd_reads(input logic [REG_W-1:0] r);
    return (r != '0) && ((fd_src_a_v && (fd_src_a == r)) || (fd_src_b_v && (fd_src_b == r)) ||
                         (fd_is_sw && (fd_rd == r)));
  endfunction

  logic load_use, sb_stall;
  assign load_use = dx_is_lw && dx_dst_v && fd_reads(dx_dst);

  md_state_e        state, state_nx;
  logic [REG_W-1:0] md_rd_q, md_rd_nx;
  logic [TCW-1:0]   cyc, cyc_nx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= MD_IDLE;
      md_rd_q <= '0;
      cyc     <= '0;
    end else begin
      state   <= state_nx;
      md_rd_q <= md_rd_nx;
      cyc     <= cyc_nx;
    end
  end

  // A start while already busy (without a retire) is ignored.
  always_comb begin
    state_nx = state;
    md_rd_nx = md_rd_q;
    cyc_nx   = cyc;
    case (state)
      MD_IDLE: begin
        if (md_start) begin
          state_nx = MD_BUSY; md_rd_nx = dx_rd; cyc_nx = '0;
        end
      end
      MD_BUSY, MD_TOUT: begin
        if (md_ready && md_start) begin
          state_nx = MD_BUSY; md_rd_nx = dx_rd; cyc_nx = '0;
        end else if (md_ready) begin
          state_nx = MD_IDLE; cyc_nx = '0;
        end else if (state == MD_BUSY) begin
          cyc_nx = cyc + TCW'(1);
          if (cyc == TCW'(MD_TIMEOUT - 1)) state_nx = MD_TOUT;
        end
      end
      default: state_nx = MD_IDLE;
    endcase
  end

  assign md_busy    = (state != MD_IDLE);
  assign md_timeout = (state == MD_TOUT);
  assign md_rd      = md_rd_q;

  // md_ready bypasses the retiring result, so it drops the stall this cycle.
  assign sb_stall = reset_n && md_busy && !md_ready &&
                    (fd_reads(md_rd_q) || fd_reads(R30) || fd_is_md ||
                     (fd_dst_v && (fd_dst == md_rd_q)));
  assign stall = load_use || sb_stall;

`ifdef BYPASS_PERF_EN
  logic [CNT_W-1:0] perf_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     perf_q <= '0;
    else if (stall && (perf_q != '1)) perf_q <= perf_q + CNT_W'(1);
  end
  assign stall_count = perf_q;
`else
  assign stall_count = '0;
`endif

endmodule
